// File: rtl/cam_timing_gen.sv
// Synthetic camera source: FV window with nested LV pulses and a selectable test pattern.
// Geometry is fixed by parameters; the pattern is latched once per frame.
module cam_timing_gen #(
  parameter int ACTIVE_PIXELS = 720,
  parameter int HBLANK        = 138,
  parameter int ACTIVE_LINES  = 288,
  parameter int FV_LEAD       = 4,
  parameter int FV_TRAIL      = 4,
  parameter int VBLANK_CYCLES = 1000,
  parameter int DATA_W        = 8
) (
  input  logic              cam_pclk,
  input  logic              cam_reset,
  input  logic              gen_enable,
  input  logic [1:0]        pattern_sel,
  output logic              cam_frame_valid,
  output logic              cam_line_valid,
  output logic [DATA_W-1:0] cam_data,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FV_LEAD, S_ACTIVE, S_HBLANK, S_FV_TRAIL, S_VBLANK
  } state_t;

  localparam logic [15:0] LEAD_LAST  = 16'(FV_LEAD - 1);
  localparam logic [15:0] HBL_LAST   = 16'(HBLANK - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(FV_TRAIL - 1);
  localparam logic [15:0] VBL_LAST   = 16'(VBLANK_CYCLES - 1);
  localparam logic [10:0] X_LAST     = 11'(ACTIVE_PIXELS - 1);
  localparam logic [9:0]  Y_LAST     = 10'(ACTIVE_LINES - 1);

  state_t      state;
  logic [15:0] phase;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  pat;

  // Pixel value for a given position; only the low byte carries pattern data.
  function automatic logic [DATA_W-1:0] pixel(input logic [1:0] sel,
                                               input logic [7:0] px,
                                               input logic [7:0] py);
    logic [7:0] v;
    case (sel)
      2'd0:    v = px;
      2'd1:    v = py;
      2'd2:    v = (px[3] ^ py[3]) ? 8'hFF : 8'h00;
      default: v = 8'h80;
    endcase
    pixel      = '0;
    pixel[7:0] = v;
  endfunction

  always_ff @(posedge cam_pclk) begin
    if (cam_reset) begin
      state           <= S_IDLE;
      phase           <= '0;
      x               <= '0;
      y               <= '0;
      pat             <= '0;
      cam_frame_valid <= 1'b0;
      cam_line_valid  <= 1'b0;
      cam_data        <= '0;
      frame_start     <= 1'b0;
      frame_count     <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gen_enable) begin
            state           <= S_FV_LEAD;
            phase           <= '0;
            x               <= '0;
            y               <= '0;
            pat             <= pattern_sel;
            cam_frame_valid <= 1'b1;
            frame_start     <= 1'b1;
          end
        end
        S_FV_LEAD: begin
          if (phase == LEAD_LAST) begin
            state          <= S_ACTIVE;
            phase          <= '0;
            x              <= '0;
            cam_line_valid <= 1'b1;
            cam_data       <= pixel(pat, 8'd0, y[7:0]);
          end else begin
            phase <= phase + 16'd1;
          end
        end
        S_ACTIVE: begin
          if (x == X_LAST) begin
            cam_line_valid <= 1'b0;
            cam_data       <= '0;
            phase          <= '0;
            state          <= (y == Y_LAST) ? S_FV_TRAIL : S_HBLANK;
          end else begin
            x        <= x + 11'd1;
            cam_data <= pixel(pat, x[7:0] + 8'd1, y[7:0]);
          end
        end
        S_HBLANK: begin
          if (phase == HBL_LAST) begin
            state          <= S_ACTIVE;
            phase          <= '0;
            x              <= '0;
            y              <= y + 10'd1;
            cam_line_valid <= 1'b1;
            cam_data       <= pixel(pat, 8'd0, y[7:0] + 8'd1);
          end else begin
            phase <= phase + 16'd1;
          end
        end
        S_FV_TRAIL: begin
          if (phase == TRAIL_LAST) begin
            state           <= S_VBLANK;
            phase           <= '0;
            cam_frame_valid <= 1'b0;
            frame_count     <= frame_count + 16'd1;
          end else begin
            phase <= phase + 16'd1;
          end
        end
        S_VBLANK: begin
          // Run request is only honoured here, so a frame is never cut short.
          if (phase == VBL_LAST) begin
            phase <= '0;
            if (gen_enable) begin
              state           <= S_FV_LEAD;
              x               <= '0;
              y               <= '0;
              pat             <= pattern_sel;
              cam_frame_valid <= 1'b1;
              frame_start     <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            phase <= phase + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam_timing_gen.md
# cam_timing_gen

Synthetic camera-side source for the capture path. Produces `cam_frame_valid`, `cam_line_valid` and pixel data with the same framing the TVP capture delivers: lines are LV pulses nested inside an FV window. Used as the stimulus end for frame/line counters and line buffers, both on the bench and in-system when no camera is attached. Frame geometry is set by parameters; the test pattern is selectable at runtime.

## Interface
- `ACTIVE_PIXELS`, 720: LV-high cycles per line; range 1..2047.
- `HBLANK`, 138: LV-low cycles between lines inside FV; ≥1.
- `ACTIVE_LINES`, 288: lines per frame; range 1..1023.
- `FV_LEAD`, 4: cycles from the FV rise to the first LV rise; ≥1.
- `FV_TRAIL`, 4: cycles from the last LV fall to the FV fall; ≥1.
- `VBLANK_CYCLES`, 1000: FV-low cycles between frames; range 1..65535.
- `DATA_W`, 8: pixel width; ≥8.
- `cam_pclk` in 1: pixel clock; the only clock.
- `cam_reset` in 1: synchronous, active-high reset.
- `gen_enable` in 1: run request. Sampled only in IDLE and at the end of VBLANK.
- `pattern_sel` in 2: 0 = H ramp, 1 = V ramp, 2 = checker, 3 = flat. Latched at each frame start.
- `cam_frame_valid` out 1: frame window.
- `cam_line_valid` out 1: active pixel strobe.
- `cam_data` out DATA_W: pixel value; 0 whenever LV is low.
- `frame_start` out 1: one-cycle strobe, high in the first FV-high cycle.
- `frame_count` out 16: completed frames; increments on the FV fall; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, FV_LEAD, ACTIVE, HBLANK, FV_TRAIL, VBLANK. All outputs are registered and Moore-decoded.
- IDLE: FV=LV=0, data=0. If `gen_enable`=1 at an edge, enter FV_LEAD on that edge:
  - FV goes 1, `frame_start` pulses.
  - `pattern_sel` is latched.
  - Line index is cleared.
- FV_LEAD: FV=1, LV=0 for FV_LEAD cycles, then go to ACTIVE.
- ACTIVE: FV=1, LV=1 for ACTIVE_PIXELS cycles. The pixel index x counts 0..ACTIVE_PIXELS-1.
  - If line index y < ACTIVE_LINES-1, go to HBLANK.
  - Otherwise go to FV_TRAIL.
- HBLANK: FV=1, LV=0 for HBLANK cycles. Increment y, then go to ACTIVE.
- FV_TRAIL: FV=1, LV=0 for FV_TRAIL cycles. The exit edge drops FV and increments `frame_count`. Go to VBLANK.
- VBLANK: FV=0 for VBLANK_CYCLES cycles. On exit:
  - If `gen_enable`=1, go to FV_LEAD (same actions as leaving IDLE).
  - Otherwise go to IDLE.
- Dropping `gen_enable` mid-frame has no effect until the end of VBLANK. A frame is never truncated.
- Pattern (low 8 bits; upper DATA_W-8 bits are 0):
  - H ramp: x[7:0].
  - V ramp: y[7:0].
  - Checker: 0xFF if x[3]^y[3], else 0x00.
  - Flat: 0x80.
- Counter widths: x 11 b, y 10 b, phase counter 16 b. No arithmetic overflow is possible within the parameter ranges.
- Every LV fall occurs while FV=1, so a downstream line counter sees exactly ACTIVE_LINES falling edges per frame.

## Timing
- Reset (`cam_reset`=1 at an edge) forces the next state:
  - State IDLE.
  - FV=LV=0, `cam_data`=0, `frame_start`=0, `frame_count`=0.
  - All internal counters 0.
- Reset mid-frame aborts immediately. `frame_count` does not increment for the aborted frame.
- Latency: with `gen_enable` sampled 1 in IDLE at edge k, FV=1 and `frame_start`=1 are visible after edge k. The first LV rise follows FV_LEAD cycles later.
- Frame period P = FV_LEAD + ACTIVE_LINES·ACTIVE_PIXELS + (ACTIVE_LINES-1)·HBLANK + FV_TRAIL + VBLANK_CYCLES.
- Consecutive `frame_start` pulses are exactly P cycles apart while `gen_enable` is held high.
- ACTIVE_LINES=1: ACTIVE goes directly to FV_TRAIL and no HBLANK occurs.
- `pattern_sel` changes mid-frame take effect at the next `frame_start` only.

## Test plan
Bench parameters for all scenarios: ACTIVE_PIXELS=4, HBLANK=2, ACTIVE_LINES=3, FV_LEAD=2, FV_TRAIL=2, VBLANK_CYCLES=5. This gives P=25.

1. Release reset, `gen_enable`=1, `pattern_sel`=0 → `frame_start` every 25 cycles. Each frame shows 3 LV pulses of 4 cycles, `cam_data` 0,1,2,3 per line. `frame_count` reads 1,2,3 after each FV fall.
2. Connect `cam_frame_line_counter` downstream → `lines_per_frame_last`=3 at the second FV rise and every rise after.
3. `pattern_sel`=1 → lines carry data 0x00, 0x01, 0x02. Switch to 2 mid-frame → the current frame stays the V ramp; the next frame's data is checker (x,y<8 → all 0x00).
4. Drop `gen_enable` during line 2 → the frame completes (LV count 3, `frame_count` increments), VBLANK lasts 5 cycles, then IDLE with FV=0 held indefinitely.
5. Assert `cam_reset` for one cycle during ACTIVE → next cycle FV=LV=0, `frame_count`=0. Re-enable → FV rises one edge after `gen_enable` is sampled.
6. Check the invariants every cycle across 100 frames:
   - LV never 1 while FV is 0.
   - `cam_data`=0 when LV is 0.
   - Exactly one `frame_start` per FV rise.
